jt10_adpcma_seq: RTL and testbench

JT10_ADPCMA_SEQ -- requirements
Module: jt10_adpcma_seq

---
 rtl/jt10_adpcma_seq.sv | 214 +++++++++++++++++++++
 tb/tb_jt10_adpcma_seq.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jt10_adpcma_seq.sv
// ADPCM-A sample sequencer: six channels share one slot counter and one
// byte-wide ROM port. Each channel streams nibbles (high first) from
// {start,8'h00} up to {end,8'hFF}, then stops.
// Optional build macro: JT10_ADPCMA_EOS_EN enables the end-of-sample flags.
module jt10_adpcma_seq (
    input  logic        rst_n,
    input  logic        clk,
    input  logic        cen,
    input  logic        wr_en,
    input  logic [2:0]  wr_ch,
    input  logic        wr_sel,
    input  logic [15:0] wr_data,
    input  logic [5:0]  kon,
    input  logic [5:0]  koff,
    output logic [23:0] rom_addr,
    output logic        rom_cs,
    input  logic [7:0]  rom_data,
    input  logic        rom_ok,
    output logic [3:0]  data,
    output logic        chon,
    output logic [2:0]  slot,
    output logic [5:0]  active,
    output logic [5:0]  eos,
    input  logic [5:0]  eos_clr,
    output logic        underrun
);

    typedef enum logic {F_IDLE, F_WAIT} fetch_state_t;

    fetch_state_t fst;

    logic [15:0] start_r [0:5];
    logic [15:0] end_r   [0:5];
    logic [23:0] addr_r  [0:5];
    logic [7:0]  byte_r  [0:5];
    logic [5:0]  nib_r;      // 0: high nibble next, 1: low nibble next
    logic [5:0]  valid_r;

    logic [5:0]  kon_eff;
    logic [5:0]  consume;
    logic [5:0]  low_done;
    logic [5:0]  eos_set;
    logic [5:0]  pend;
    logic [2:0]  fetch_ch;
    logic [2:0]  last_ch;
    logic [2:0]  pick;
    logic [3:0]  sum;
    logic        found;
    logic        discard;

    // Key-off overrides key-on; channels wanting a byte
    always_comb begin
        kon_eff = kon & ~koff;
        pend    = active & ~valid_r;
    end

    // Per-channel consumption on its slot visit, and end-of-sample detection
    always_comb begin
        consume  = '0;
        low_done = '0;
        eos_set  = '0;
        for (int unsigned n = 0; n < 6; n++) begin
            if (cen && slot == 3'(n) && active[n] && valid_r[n]) begin
                consume[n] = 1'b1;
                if (nib_r[n]) begin
                    low_done[n] = 1'b1;
                    if (addr_r[n] == {end_r[n], 8'hFF})
                        eos_set[n] = 1'b1;
                end
            end
        end
    end

    // Round-robin search starting just after the last served channel
    always_comb begin
        found = 1'b0;
        pick  = '0;
        sum   = '0;
        for (int unsigned i = 1; i <= 6; i++) begin
            sum = 4'(last_ch) + 4'(i);
            if (sum >= 4'd6)
                sum = sum - 4'd6;
            if (!found && pend[sum[2:0]]) begin
                found = 1'b1;
                pick  = sum[2:0];
            end
        end
    end

    // Channel registers: writes, byte capture, nibble advance, key on/off
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned n = 0; n < 6; n++) begin
                start_r[n] <= '0;
                end_r[n]   <= '0;
                addr_r[n]  <= '0;
                byte_r[n]  <= '0;
            end
            nib_r   <= '0;
            valid_r <= '0;
            active  <= '0;
        end else begin
            for (int unsigned n = 0; n < 6; n++) begin
                if (wr_en && wr_ch == 3'(n)) begin
                    if (wr_sel)
                        end_r[n] <= wr_data;
                    else
                        start_r[n] <= wr_data;
                end
                if (fst == F_WAIT && rom_ok && fetch_ch == 3'(n) && !discard) begin
                    byte_r[n]  <= rom_data;
                    valid_r[n] <= 1'b1;
                end
                if (consume[n]) begin
                    if (low_done[n]) begin
                        nib_r[n]   <= 1'b0;
                        valid_r[n] <= 1'b0;
                        if (eos_set[n])
                            active[n] <= 1'b0;
                        else
                            addr_r[n] <= addr_r[n] + 24'd1;
                    end else begin
                        nib_r[n] <= 1'b1;
                    end
                end
                // key events come last so they override same-cycle updates
                if (koff[n]) begin
                    active[n] <= 1'b0;
                end else if (kon[n]) begin
                    addr_r[n]  <= {start_r[n], 8'h00};
                    nib_r[n]   <= 1'b0;
                    valid_r[n] <= 1'b0;
                    active[n]  <= 1'b1;
                end
            end
        end
    end

    // Slot counter and registered nibble output, sticky underrun
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot     <= '0;
            data     <= '0;
            chon     <= 1'b0;
            underrun <= 1'b0;
        end else if (cen) begin
            slot <= (slot == 3'd5) ? 3'd0 : slot + 3'd1;
            if (active[slot] && valid_r[slot]) begin
                data <= nib_r[slot] ? byte_r[slot][3:0] : byte_r[slot][7:4];
                chon <= 1'b1;
            end else begin
                data <= '0;
                chon <= 1'b0;
                if (active[slot])
                    underrun <= 1'b1;
            end
        end
    end

    // ROM fetch FSM: one request outstanding, rom_cs low for a cycle between
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fst      <= F_IDLE;
            rom_cs   <= 1'b0;
            rom_addr <= '0;
            fetch_ch <= '0;
            last_ch  <= 3'd5;
            discard  <= 1'b0;
        end else begin
            case (fst)
                F_IDLE: begin
                    if (found) begin
                        rom_addr <= addr_r[pick];
                        rom_cs   <= 1'b1;
                        fetch_ch <= pick;
                        last_ch  <= pick;
                        // a key-on in the issue cycle restarts the address
                        discard  <= kon_eff[pick];
                        fst      <= F_WAIT;
                    end
                end
                F_WAIT: begin
                    if (kon_eff[fetch_ch])
                        discard <= 1'b1;
                    if (rom_ok) begin
                        rom_cs <= 1'b0;
                        fst    <= F_IDLE;
                    end
                end
                default: fst <= F_IDLE;
            endcase
        end
    end

`ifdef JT10_ADPCMA_EOS_EN
    logic [5:0] eos_r;

    // End-of-sample flags: set beats clear, key-on clears
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            eos_r <= '0;
        else
            eos_r <= ((eos_r & ~eos_clr) | eos_set) & ~kon_eff;
    end

    assign eos = eos_r;
`else
    logic unused_eos_clr;

    assign unused_eos_clr = ^eos_clr;
    assign eos = '0;
`endif

endmodule

// File: tb/tb_jt10_adpcma_seq.sv
// Bench for jt10_adpcma_seq: a per-cycle behavioural model of the channel
// rules is compared against the DUT every cycle, with directed scenarios
// and literal expectations, followed by a randomized phase.
module tb_jt10_adpcma_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cen = 1'b0;
    logic        wr_en = 1'b0;
    logic [2:0]  wr_ch = '0;
    logic        wr_sel = 1'b0;
    logic [15:0] wr_data = '0;
    logic [5:0]  kon = '0;
    logic [5:0]  koff = '0;
    logic [5:0]  eos_clr = '0;
    logic [23:0] rom_addr;
    logic        rom_cs;
    logic [7:0]  rom_data = '0;
    logic        rom_ok = 1'b0;
    logic [3:0]  data;
    logic        chon;
    logic [2:0]  slot;
    logic [5:0]  active;
    logic [5:0]  eos;
    logic        underrun;

    jt10_adpcma_seq dut (
        .rst_n(rst_n), .clk(clk), .cen(cen),
        .wr_en(wr_en), .wr_ch(wr_ch), .wr_sel(wr_sel), .wr_data(wr_data),
        .kon(kon), .koff(koff),
        .rom_addr(rom_addr), .rom_cs(rom_cs), .rom_data(rom_data), .rom_ok(rom_ok),
        .data(data), .chon(chon), .slot(slot),
        .active(active), .eos(eos), .eos_clr(eos_clr), .underrun(underrun)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] rom(input logic [23:0] a);
        if (a == 24'h2B1B00)
            return 8'hA5;
        return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h3C;
    endfunction

    // ROM responder
    int         rcnt = 0;
    int         rtgt = 1;
    bit         stall_en = 1'b0;
    bit         rand_lat = 1'b0;
    logic [7:0] stall_hi = '0;

    always @(negedge clk) begin
        if (!rom_cs) begin
            rom_ok = 1'b0;
            rcnt = 0;
        end else if (!rom_ok) begin
            if (rcnt == 0)
                rtgt = (stall_en && rom_addr[23:16] == stall_hi) ? 20 :
                       (rand_lat ? int'($urandom_range(1, 3)) : 1);
            rcnt++;
            if (rcnt >= rtgt) begin
                rom_ok = 1'b1;
                rom_data = rom(rom_addr);
            end
        end
    end

    // Behavioural model state
    logic [15:0] m_start [6];
    logic [15:0] m_end   [6];
    logic [23:0] m_addr  [6];
    logic [7:0]  m_byte  [6];
    bit          m_nib   [6];
    bit          m_val   [6];
    bit          m_act   [6];
    bit          oa [6];
    bit          ov [6];
    int          m_slot, m_fc, m_last, mc;
    logic [3:0]  m_data;
    bit          m_chon, m_under, m_out, m_disc, mfound, last_cen;
    bit [5:0]    m_eos, mset;
    logic [23:0] m_raddr;

    always @(posedge clk) begin
        last_cen = cen && rst_n;
        if (!rst_n) begin
            for (int n = 0; n < 6; n++) begin
                m_start[n] = '0; m_end[n] = '0; m_addr[n] = '0; m_byte[n] = '0;
                m_nib[n] = 0; m_val[n] = 0; m_act[n] = 0;
            end
            m_slot = 0; m_data = '0; m_chon = 0; m_under = 0; m_eos = '0;
            m_out = 0; m_disc = 0; m_fc = 0; m_last = 5; m_raddr = '0;
        end else begin
            for (int n = 0; n < 6; n++) begin
                oa[n] = m_act[n];
                ov[n] = m_val[n];
            end
            mset = '0;
            // fetch: capture or pick the next hungry channel after the last one
            if (m_out) begin
                if (rom_ok) begin
                    if (!m_disc) begin
                        m_byte[m_fc] = rom_data;
                        m_val[m_fc] = 1;
                    end
                    m_out = 0;
                end
            end else begin
                mfound = 0;
                for (int i = 1; i <= 6; i++) begin
                    mc = (m_last + i) % 6;
                    if (!mfound && oa[mc] && !ov[mc]) begin
                        mfound = 1; m_out = 1; m_fc = mc; m_raddr = m_addr[mc]; m_disc = 0;
                    end
                end
                if (mfound)
                    m_last = m_fc;
            end
            // slot visit
            if (cen) begin
                if (oa[m_slot] && ov[m_slot]) begin
                    m_chon = 1;
                    m_data = m_nib[m_slot] ? m_byte[m_slot][3:0] : m_byte[m_slot][7:4];
                    if (m_nib[m_slot]) begin
                        m_nib[m_slot] = 0;
                        m_val[m_slot] = 0;
                        if (m_addr[m_slot] == {m_end[m_slot], 8'hFF}) begin
                            m_act[m_slot] = 0;
                            mset[m_slot] = 1;
                        end else begin
                            m_addr[m_slot] = m_addr[m_slot] + 24'd1;
                        end
                    end else begin
                        m_nib[m_slot] = 1;
                    end
                end else begin
                    m_chon = 0;
                    m_data = '0;
                    if (oa[m_slot])
                        m_under = 1;
                end
                m_slot = (m_slot + 1) % 6;
            end
            m_eos = (m_eos & ~eos_clr) | mset;
            for (int n = 0; n < 6; n++) begin
                if (koff[n]) begin
                    m_act[n] = 0;
                end else if (kon[n]) begin
                    m_addr[n] = {m_start[n], 8'h00};
                    m_nib[n] = 0; m_val[n] = 0; m_act[n] = 1; m_eos[n] = 0;
                    if (m_out && m_fc == n)
                        m_disc = 1;
                end
            end
            if (wr_en && wr_ch < 3'd6) begin
                if (wr_sel) m_end[wr_ch] = wr_data;
                else        m_start[wr_ch] = wr_data;
            end
        end
    end

    // Per-cycle compare and event monitors
    logic [23:0] fetch_log[$];
    logic [7:0]  ev_q[$];
    logic [23:0] last_fetch = '0;
    bit          prev_cs = 0;
    bit          saw_c00 = 0;
    bit          saw_zero = 0;
    logic [5:0]  m_actv, exp_eos;
    logic [2:0]  ev_ch;

    always @(posedge clk) begin
        #1;
        for (int n = 0; n < 6; n++)
            m_actv[n] = m_act[n];
`ifdef JT10_ADPCMA_EOS_EN
        exp_eos = m_eos;
`else
        exp_eos = '0;
`endif
        check("slot", slot, m_slot);
        check("data", data, m_data);
        check("chon", chon, m_chon);
        check("active", active, m_actv);
        check("underrun", underrun, m_under);
        check("eos", eos, exp_eos);
        check("rom_cs", rom_cs, m_out);
        check("rom_addr", rom_addr, m_raddr);
        if (rom_cs && !prev_cs) begin
            fetch_log.push_back(rom_addr);
            last_fetch = rom_addr;
            if (rom_addr == 24'h2B1C00) saw_c00 = 1;
            if (rom_addr == 24'h000000) saw_zero = 1;
        end
        prev_cs = rom_cs;
        if (chon && last_cen) begin
            ev_ch = (slot == 3'd0) ? 3'd5 : slot - 3'd1;
            ev_q.push_back({1'b0, ev_ch, data});
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        tick(1);
        rst_n = 1'b0; cen = 1'b0; kon = '0; koff = '0; wr_en = 1'b0; eos_clr = '0;
        tick(3);
        rst_n = 1'b1; cen = 1'b1;
        fetch_log.delete(); ev_q.delete();
        saw_c00 = 0; saw_zero = 0; last_fetch = '0;
    endtask

    task automatic wr(input logic [2:0] ch, input logic sel, input logic [15:0] d);
        wr_en = 1'b1; wr_ch = ch; wr_sel = sel; wr_data = d;
        tick(1);
        wr_en = 1'b0;
    endtask

    task automatic key(input logic [5:0] on, input logic [5:0] off);
        kon = on; koff = off;
        tick(1);
        kon = '0; koff = '0;
    endtask

    task automatic wait_events(input int cnt, input int budget);
        int k = 0;
        while (ev_q.size() < cnt && k < budget) begin
            tick(1);
            k++;
        end
    endtask

    task automatic wait_inactive(input int ch, input int budget, input string nm);
        int k = 0;
        while (active[ch] && k < budget) begin
            tick(1);
            k++;
        end
        check(nm, active[ch], 1'b0);
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        // reset values
        tick(3);
        check("rst_slot", slot, 3'd0);
        check("rst_data", data, 4'd0);
        check("rst_chon", chon, 1'b0);
        check("rst_rom_cs", rom_cs, 1'b0);
        check("rst_rom_addr", rom_addr, 24'd0);
        check("rst_active", active, 6'd0);
        check("rst_eos", eos, 6'd0);
        check("rst_underrun", underrun, 1'b0);

        // single channel: nibble order, end of sample
        do_reset();
        wr(3'd0, 1'b0, 16'h2B1B);
        wr(3'd0, 1'b1, 16'h2B1B);
        ev_q.delete();
        key(6'b000001, 6'b0);
        wait_events(2, 200);
        check("A_hi_nibble", (ev_q.size() >= 1) ? ev_q[0] : 8'hFF, 8'h0A);
        check("A_lo_nibble", (ev_q.size() >= 2) ? ev_q[1] : 8'hFF, 8'h05);
        wait_inactive(0, 4000, "A_end_active");
        check("A_last_fetch", last_fetch, 24'h2B1BFF);
        check("A_no_overrun_addr", saw_c00, 1'b0);
`ifdef JT10_ADPCMA_EOS_EN
        check("A_eos_set", eos[0], 1'b1);
`else
        check("A_eos_tied", eos[0], 1'b0);
`endif
        eos_clr = 6'b000001;
        tick(1);
        eos_clr = '0;
        tick(1);
        check("A_eos_cleared", eos[0], 1'b0);

        // all six keyed together: fetch order
        do_reset();
        for (int n = 0; n < 6; n++) begin
            wr(3'(n), 1'b0, 16'h1000 + 16'(n * 256));
            wr(3'(n), 1'b1, 16'h1004 + 16'(n * 256));
        end
        wr(3'd6, 1'b0, 16'hDEAD);
        wr(3'd7, 1'b1, 16'hBEEF);
        fetch_log.delete();
        key(6'h3F, 6'h00);
        tick(20);
        for (int i = 0; i < 6; i++)
            check("B_fetch_order", (fetch_log.size() > i) ? 32'(fetch_log[i][23:16]) : 32'hFFFF, 32'(16 + i));

        // withheld byte on channel 2
        do_reset();
        wr(3'd2, 1'b0, 16'h5500);
        wr(3'd2, 1'b1, 16'h5501);
        stall_hi = 8'h55;
        stall_en = 1'b1;
        ev_q.delete();
        key(6'b000100, 6'b0);
        tick(12);
        check("C_underrun", underrun, 1'b1);
        check("C_no_output", ev_q.size(), 0);
        wait_events(1, 60);
        stall_en = 1'b0;
        wait_events(2, 60);
        check("C_hi_nibble", (ev_q.size() >= 1) ? ev_q[0] : 8'hFF, 8'h26);
        check("C_lo_nibble", (ev_q.size() >= 2) ? ev_q[1] : 8'hFF, 8'h29);

        // kon and koff together
        do_reset();
        wr(3'd3, 1'b0, 16'h6600);
        wr(3'd3, 1'b1, 16'h6600);
        fetch_log.delete();
        key(6'b001000, 6'b001000);
        tick(30);
        check("D_active", active, 6'd0);
        check("D_no_fetch", fetch_log.size(), 0);

        // reset during an outstanding fetch
        do_reset();
        wr(3'd1, 1'b0, 16'h7700);
        stall_hi = 8'h77;
        stall_en = 1'b1;
        key(6'b000010, 6'b0);
        k = 0;
        while (!rom_cs && k < 30) begin
            tick(1);
            k++;
        end
        check("E_cs_before_reset", rom_cs, 1'b1);
        rst_n = 1'b0;
        #1;
        check("E_cs_dropped", rom_cs, 1'b0);
        check("E_addr_zero", rom_addr, 24'd0);
        check("E_active_zero", active, 6'd0);
        check("E_slot_zero", slot, 3'd0);
        tick(2);
        stall_en = 1'b0;
        cen = 1'b1;
        rst_n = 1'b1;
        @(posedge clk);
        #2;
        check("E_first_cen_slot0", slot, 3'd1);

        // address wrap at 2^24
        do_reset();
        wr(3'd5, 1'b0, 16'hFFFF);
        wr(3'd5, 1'b1, 16'h0000);
        key(6'b100000, 6'b0);
        wait_inactive(5, 8000, "G_wrap_end_active");
        check("G_wrap_seen", saw_zero, 1'b1);
        check("G_last_fetch", last_fetch, 24'h0000FF);

        // randomized traffic
        do_reset();
        rand_lat = 1'b1;
        for (int n = 0; n < 6; n++) begin
            wr_data = 16'($urandom);
            wr(3'(n), 1'b0, wr_data);
            wr(3'(n), 1'b1, wr_data + 16'($urandom_range(0, 1)));
        end
        for (int cyc = 0; cyc < 4000; cyc++) begin
            cen = ($urandom_range(0, 9) < 7);
            kon = '0; koff = '0; eos_clr = '0; wr_en = 1'b0;
            if ($urandom_range(0, 29) == 0) kon = 6'($urandom);
            if ($urandom_range(0, 59) == 0) koff = 6'($urandom);
            if ($urandom_range(0, 19) == 0) eos_clr = 6'($urandom);
            if ($urandom_range(0, 19) == 0) begin
                wr_en = 1'b1;
                wr_ch = 3'($urandom_range(0, 7));
                wr_sel = 1'($urandom_range(0, 1));
                wr_data = 16'($urandom);
            end
            tick(1);
        end
        kon = '0; koff = '0; eos_clr = '0; wr_en = 1'b0; cen = 1'b1;
        rand_lat = 1'b0;
        tick(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
